uart_alu_top_level: RTL and testbench

Board-level top that turns a serial line into a calculator: three UART bytes (operand A, operand B, opcode) arrive on RsRx, an 8-bit ALU evaluates them, and the one-byte result is returned on RsTx. It contains a 16x-oversampling baud generator, a UART receiver, an operand-capture FSM, an ALU and a UART transmitter, all in one clock domain.

---
 rtl/uart_alu_pkg.sv | 50 +++++
 rtl/uart_alu_top_level_if.sv | 16 +
 rtl/uart_alu_top_level_capture.sv | 59 +++++
 rtl/uart_alu_top_level_uart.sv | 197 +++++++++++++++++++
 rtl/uart_alu_top_level.sv | 60 ++++++
 tb/tb_uart_alu_top_level.sv | 201 ++++++++++++++++++++
 6 files changed

// File: rtl/uart_alu_pkg.sv
// Shared constants for the serial calculator: opcodes, FSM state codes,
// frame defaults and the 8-bit ALU evaluation function.
package uart_alu_pkg;

  localparam int unsigned N_DATA_DEF = 8;
  localparam int unsigned M_STOP_DEF = 1;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_PAR   = 3'd3;
  localparam logic [2:0] RX_STOP  = 3'd4;

  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_START = 3'd1;
  localparam logic [2:0] TX_DATA  = 3'd2;
  localparam logic [2:0] TX_PAR   = 3'd3;
  localparam logic [2:0] TX_STOP  = 3'd4;

  localparam logic [1:0] CAP_WAIT_A  = 2'd0;
  localparam logic [1:0] CAP_WAIT_B  = 2'd1;
  localparam logic [1:0] CAP_WAIT_OP = 2'd2;
  localparam logic [1:0] CAP_SEND    = 2'd3;

  // Signed 8-bit ALU; unknown opcodes return zero.
  function automatic logic [7:0] alu_eval(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SRA:  return 8'($signed(a) >>> b);
      OP_SRL:  return a >> b;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/uart_alu_top_level_if.sv
// Byte handshake between the UART engines and the capture FSM.
//   rx_done/rx_data : received byte strobe and value (UART -> capture)
//   tx_start/tx_data: transmit request and byte     (capture -> UART)
//   tx_done         : end of last stop bit          (UART -> capture)
interface uart_alu_top_level_if #(
  parameter int unsigned W = 8
);
  logic         rx_done;
  logic [W-1:0] rx_data;
  logic         tx_start;
  logic [W-1:0] tx_data;
  logic         tx_done;

  modport master (input rx_done, rx_data, tx_done, output tx_start, tx_data);
  modport slave  (output rx_done, rx_data, tx_done, input tx_start, tx_data);
endinterface

// File: rtl/uart_alu_top_level_capture.sv
// Operand capture FSM: collects A, B and opcode, launches the ALU result
// on the transmitter and waits for it to finish.
// Ports: i_clk, rst_n (async active-low), bus (master side of the handshake).
module uart_alu_top_level_capture
  import uart_alu_pkg::*;
#(
  parameter int unsigned N_DATA = N_DATA_DEF
) (
  input  logic i_clk,
  input  logic rst_n,
  uart_alu_top_level_if.master bus
);
  logic [1:0]        st, st_n;
  logic [7:0]        a_q, a_n, b_q, b_n;
  logic [5:0]        op_q, op_n;
  logic              sent_q, sent_n;
  logic              start_q, start_n;
  logic [N_DATA-1:0] data_q, data_n;

  assign bus.tx_start = start_q;
  assign bus.tx_data  = data_q;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= CAP_WAIT_A; a_q <= '0; b_q <= '0; op_q <= '0;
      sent_q <= 1'b0; start_q <= 1'b0; data_q <= '0;
    end else begin
      st <= st_n; a_q <= a_n; b_q <= b_n; op_q <= op_n;
      sent_q <= sent_n; start_q <= start_n; data_q <= data_n;
    end
  end

  // Bytes arriving during SEND are ignored.
  always_comb begin
    st_n = st; a_n = a_q; b_n = b_q; op_n = op_q;
    sent_n = sent_q; start_n = 1'b0; data_n = data_q;
    case (st)
      CAP_WAIT_A:  if (bus.rx_done) begin a_n = 8'(bus.rx_data); st_n = CAP_WAIT_B; end
      CAP_WAIT_B:  if (bus.rx_done) begin b_n = 8'(bus.rx_data); st_n = CAP_WAIT_OP; end
      CAP_WAIT_OP: if (bus.rx_done) begin
        op_n   = 6'(bus.rx_data);
        sent_n = 1'b0;
        st_n   = CAP_SEND;
      end
      CAP_SEND: begin
        if (!sent_q) begin
          start_n = 1'b1;
          data_n  = N_DATA'(alu_eval(a_q, b_q, op_q));
          sent_n  = 1'b1;
        end else if (bus.tx_done) begin
          sent_n = 1'b0;
          st_n   = CAP_WAIT_A;
        end
      end
      default: st_n = CAP_WAIT_A;
    endcase
  end

endmodule

// File: rtl/uart_alu_top_level_uart.sv
// UART receiver and transmitter sharing one 16x oversampling tick.
// Optional macro UART_PARITY_EN adds an even-parity bit after the data bits.
// Ports: i_clk, rst_n (async active-low), tick (16x baud strobe),
//        rx_line (synchronised serial in), tx_line (serial out, idles high),
//        bus (slave side of the byte handshake).
module uart_alu_top_level_uart
  import uart_alu_pkg::*;
#(
  parameter int unsigned N_DATA = N_DATA_DEF,
  parameter int unsigned M_STOP = M_STOP_DEF
) (
  input  logic i_clk,
  input  logic rst_n,
  input  logic tick,
  input  logic rx_line,
  output logic tx_line,
  uart_alu_top_level_if.slave bus
);
  localparam int unsigned BIT_W  = (N_DATA > 1) ? $clog2(N_DATA) : 1;
  localparam int unsigned STOP_W = (M_STOP > 1) ? $clog2(M_STOP) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(N_DATA - 1);
  localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(M_STOP - 1);

  logic [2:0]        rx_state, rx_state_n;
  logic [3:0]        rx_cnt, rx_cnt_n;
  logic [BIT_W-1:0]  rx_bit, rx_bit_n;
  logic [STOP_W-1:0] rx_stop, rx_stop_n;
  logic [N_DATA-1:0] rx_sh, rx_sh_n;
  logic              rx_done, rx_done_n;
`ifdef UART_PARITY_EN
  logic              rx_perr, rx_perr_n;
`endif

  logic [2:0]        tx_state, tx_state_n;
  logic [3:0]        tx_cnt, tx_cnt_n;
  logic [BIT_W-1:0]  tx_bit, tx_bit_n;
  logic [STOP_W-1:0] tx_stop, tx_stop_n;
  logic [N_DATA-1:0] tx_sh, tx_sh_n;
  logic              tx_armed, tx_armed_n;
  logic              tx_line_n;
  logic              tx_done, tx_done_n;
`ifdef UART_PARITY_EN
  logic              tx_par, tx_par_n;
`endif

  assign bus.rx_done = rx_done;
  assign bus.rx_data = rx_sh;
  assign bus.tx_done = tx_done;

  // State registers for both engines.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE; rx_cnt <= '0; rx_bit <= '0; rx_stop <= '0;
      rx_sh    <= '0;      rx_done <= 1'b0;
      tx_state <= TX_IDLE; tx_cnt <= '0; tx_bit <= '0; tx_stop <= '0;
      tx_sh    <= '0;      tx_armed <= 1'b0; tx_line <= 1'b1; tx_done <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr  <= 1'b0;    tx_par <= 1'b0;
`endif
    end else begin
      rx_state <= rx_state_n; rx_cnt <= rx_cnt_n; rx_bit <= rx_bit_n; rx_stop <= rx_stop_n;
      rx_sh    <= rx_sh_n;    rx_done <= rx_done_n;
      tx_state <= tx_state_n; tx_cnt <= tx_cnt_n; tx_bit <= tx_bit_n; tx_stop <= tx_stop_n;
      tx_sh    <= tx_sh_n;    tx_armed <= tx_armed_n; tx_line <= tx_line_n; tx_done <= tx_done_n;
`ifdef UART_PARITY_EN
      rx_perr  <= rx_perr_n;  tx_par <= tx_par_n;
`endif
    end
  end

  // Receiver: centre-sample 8 ticks after the start edge, then every 16.
  always_comb begin
    rx_state_n = rx_state; rx_cnt_n = rx_cnt; rx_bit_n = rx_bit; rx_stop_n = rx_stop;
    rx_sh_n    = rx_sh;    rx_done_n = 1'b0;
`ifdef UART_PARITY_EN
    rx_perr_n  = rx_perr;
`endif
    if (tick) begin
      case (rx_state)
        RX_IDLE: if (!rx_line) begin rx_state_n = RX_START; rx_cnt_n = '0; end
        RX_START: begin
          if (rx_cnt == 4'd7) begin
            rx_cnt_n   = '0;
            rx_bit_n   = '0;
            rx_state_n = rx_line ? RX_IDLE : RX_DATA;   // high again: glitch
          end else rx_cnt_n = rx_cnt + 4'd1;
        end
        RX_DATA: begin
          if (rx_cnt == 4'd15) begin
            rx_cnt_n = '0;
            rx_sh_n  = {rx_line, rx_sh[N_DATA-1:1]};
            if (rx_bit == LAST_BIT) begin
              rx_stop_n = '0;
`ifdef UART_PARITY_EN
              rx_state_n = RX_PAR;
`else
              rx_state_n = RX_STOP;
`endif
            end else rx_bit_n = rx_bit + BIT_W'(1);
          end else rx_cnt_n = rx_cnt + 4'd1;
        end
`ifdef UART_PARITY_EN
        RX_PAR: begin
          if (rx_cnt == 4'd15) begin
            rx_cnt_n   = '0;
            rx_perr_n  = rx_line ^ (^rx_sh);
            rx_state_n = RX_STOP;
          end else rx_cnt_n = rx_cnt + 4'd1;
        end
`endif
        RX_STOP: begin
          if (rx_cnt == 4'd15) begin
            rx_cnt_n = '0;
            if (!rx_line) rx_state_n = RX_IDLE;         // framing error: drop byte
            else if (rx_stop == LAST_STOP) begin
              rx_state_n = RX_IDLE;
`ifdef UART_PARITY_EN
              rx_done_n  = !rx_perr;
`else
              rx_done_n  = 1'b1;
`endif
            end else rx_stop_n = rx_stop + STOP_W'(1);
          end else rx_cnt_n = rx_cnt + 4'd1;
        end
        default: rx_state_n = RX_IDLE;
      endcase
    end
  end

  // Transmitter: a request arms it; the start bit begins on the next tick.
  always_comb begin
    tx_state_n = tx_state; tx_cnt_n = tx_cnt; tx_bit_n = tx_bit; tx_stop_n = tx_stop;
    tx_sh_n    = tx_sh;    tx_armed_n = tx_armed; tx_line_n = tx_line; tx_done_n = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_n   = tx_par;
`endif
    case (tx_state)
      TX_IDLE: begin
        tx_line_n = 1'b1;
        if (bus.tx_start) begin
          tx_sh_n    = bus.tx_data;
          tx_armed_n = 1'b1;
`ifdef UART_PARITY_EN
          tx_par_n   = ^bus.tx_data;
`endif
        end else if (tx_armed && tick) begin
          tx_armed_n = 1'b0;
          tx_state_n = TX_START;
          tx_line_n  = 1'b0;
          tx_cnt_n   = '0;
        end
      end
      TX_START: if (tick) begin
        if (tx_cnt == 4'd15) begin
          tx_cnt_n = '0; tx_bit_n = '0; tx_line_n = tx_sh[0]; tx_state_n = TX_DATA;
        end else tx_cnt_n = tx_cnt + 4'd1;
      end
      TX_DATA: if (tick) begin
        if (tx_cnt == 4'd15) begin
          tx_cnt_n = '0;
          if (tx_bit == LAST_BIT) begin
            tx_stop_n = '0;
`ifdef UART_PARITY_EN
            tx_line_n  = tx_par;
            tx_state_n = TX_PAR;
`else
            tx_line_n  = 1'b1;
            tx_state_n = TX_STOP;
`endif
          end else begin
            tx_bit_n  = tx_bit + BIT_W'(1);
            tx_sh_n   = tx_sh >> 1;
            tx_line_n = tx_sh[1];
          end
        end else tx_cnt_n = tx_cnt + 4'd1;
      end
`ifdef UART_PARITY_EN
      TX_PAR: if (tick) begin
        if (tx_cnt == 4'd15) begin
          tx_cnt_n = '0; tx_line_n = 1'b1; tx_state_n = TX_STOP;
        end else tx_cnt_n = tx_cnt + 4'd1;
      end
`endif
      TX_STOP: if (tick) begin
        if (tx_cnt == 4'd15) begin
          tx_cnt_n = '0;
          if (tx_stop == LAST_STOP) begin
            tx_state_n = TX_IDLE;
            tx_done_n  = 1'b1;
          end else tx_stop_n = tx_stop + STOP_W'(1);
        end else tx_cnt_n = tx_cnt + 4'd1;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_alu_top_level.sv
// Serial calculator top: RsRx bytes A, B, op -> ALU -> result byte on RsTx.
// Optional macro UART_PARITY_EN enables even parity on both directions.
// Ports: i_clk (system clock), i_btnC (async active-low reset),
//        RsRx (serial in, idles high), RsTx (serial out, idles high).
module uart_alu_top_level
  import uart_alu_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 651,
  parameter int unsigned N_DATA   = N_DATA_DEF,
  parameter int unsigned M_STOP   = M_STOP_DEF
) (
  input  logic i_clk,
  input  logic i_btnC,
  input  logic RsRx,
  output logic RsTx
);
  localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [CNT_W-1:0] brgen_cnt;
  logic             brgen_valid_urx;
  logic [1:0]       rx_sync;

  // Two-flop synchroniser on the asynchronous serial input.
  always_ff @(posedge i_clk or negedge i_btnC) begin
    if (!i_btnC) rx_sync <= 2'b11;
    else         rx_sync <= {rx_sync[0], RsRx};
  end

  // Free-running 16x baud tick shared by receiver and transmitter.
  always_ff @(posedge i_clk or negedge i_btnC) begin
    if (!i_btnC) begin
      brgen_cnt       <= '0;
      brgen_valid_urx <= 1'b0;
    end else if (brgen_cnt == CNT_W'(BAUD_DIV - 1)) begin
      brgen_cnt       <= '0;
      brgen_valid_urx <= 1'b1;
    end else begin
      brgen_cnt       <= brgen_cnt + CNT_W'(1);
      brgen_valid_urx <= 1'b0;
    end
  end

  uart_alu_top_level_if #(.W(N_DATA)) u_bus ();

  uart_alu_top_level_uart #(.N_DATA(N_DATA), .M_STOP(M_STOP)) u_uart (
    .i_clk   (i_clk),
    .rst_n   (i_btnC),
    .tick    (brgen_valid_urx),
    .rx_line (rx_sync[1]),
    .tx_line (RsTx),
    .bus     (u_bus)
  );

  uart_alu_top_level_capture #(.N_DATA(N_DATA)) u_cap (
    .i_clk (i_clk),
    .rst_n (i_btnC),
    .bus   (u_bus)
  );

endmodule

// File: tb/tb_uart_alu_top_level.sv
// Self-checking bench for uart_alu_top_level: serial stimulus, serial
// result decoding and an arithmetic reference model of the calculator.
module tb_uart_alu_top_level;
  import uart_alu_pkg::*;

  localparam int unsigned BD      = 4;
  localparam int unsigned BIT_CLK = 16 * BD;
`ifdef UART_PARITY_EN
  localparam int unsigned FRAME = 11;
`else
  localparam int unsigned FRAME = 10;
`endif
  localparam int unsigned TMO = 4 * FRAME * BIT_CLK;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic rx_line = 1'b1;
  logic tx_line;
  int   n_chk   = 0;
  int   n_pass  = 0;
  int   rx_cnt  = 0;
  int   txd_cnt = 0;
  logic [7:0] last_rx = '0;
  logic [7:0] last_tx = '0;

  always #5 clk = ~clk;

  uart_alu_top_level #(.BAUD_DIV(BD)) dut (
    .i_clk (clk),
    .i_btnC(rst_n),
    .RsRx  (rx_line),
    .RsTx  (tx_line)
  );

  // Mirror of the internal byte handshake, used to observe RX and TX requests.
  uart_alu_top_level_if #(.W(8)) mon_if ();
  assign mon_if.rx_done  = dut.u_bus.rx_done;
  assign mon_if.rx_data  = dut.u_bus.rx_data;
  assign mon_if.tx_start = dut.u_bus.tx_start;
  assign mon_if.tx_data  = dut.u_bus.tx_data;
  assign mon_if.tx_done  = dut.u_bus.tx_done;

  always @(negedge clk) begin
    if (mon_if.rx_done)  begin rx_cnt++; last_rx = mon_if.rx_data; end
    if (mon_if.tx_start) last_tx = mon_if.tx_data;
    if (mon_if.tx_done)  txd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Calculator behaviour from plain integer arithmetic.
  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] op);
    int ia, ib, sa, q, sh;
    ia = int'(a); ib = int'(b);
    sa = (ia >= 128) ? ia - 256 : ia;
    case (int'(op) % 64)
      32: q = ia + ib;
      34: q = ia - ib;
      36: q = ia & ib;
      37: q = ia | ib;
      38: q = ia ^ ib;
      39: q = ~(ia | ib);
      3: begin
        sh = (ib > 8) ? 8 : ib;
        q  = sa / (1 << sh);
        if (sa < 0 && (sa % (1 << sh)) != 0) q = q - 1;   // floor division
      end
      2: q = (ib >= 8) ? 0 : ia / (1 << ib);
      default: q = 0;
    endcase
    return 8'(q & 255);
  endfunction

  task automatic send_bit(input logic v);
    rx_line = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
    send_bit(^d);
`endif
    send_bit(1'b1);
  endtask

  task automatic recv_byte(output logic [7:0] d, output logic ok);
    int n;
    logic par_ok;
    ok = 1'b0; d = '0; n = 0; par_ok = 1'b1;
    while (tx_line !== 1'b0 && n < int'(TMO)) begin @(negedge clk); n++; end
    if (tx_line !== 1'b0) return;
    repeat (BIT_CLK / 2) @(negedge clk);
    if (tx_line !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT_CLK) @(negedge clk);
      d[i] = tx_line;
    end
`ifdef UART_PARITY_EN
    repeat (BIT_CLK) @(negedge clk);
    par_ok = (tx_line === ^d);
`endif
    repeat (BIT_CLK) @(negedge clk);
    ok = (tx_line === 1'b1) && par_ok;
  endtask

  task automatic run_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op);
    logic [7:0] got, exp;
    logic       ok;
    int         d0;
    exp = model(a, b, op);
    d0  = txd_cnt;
    fork
      begin send_byte(a); send_byte(b); send_byte(op); end
      recv_byte(got, ok);
    join
    repeat (BIT_CLK) @(negedge clk);
    chk({tag, "_frame"}, 32'(ok), 32'd1);
    chk({tag, "_rsTx"}, 32'(got), 32'(exp));
    chk({tag, "_alu"}, 32'(last_tx), 32'(exp));
    chk({tag, "_lastrx"}, 32'(last_rx), 32'(op));
    chk({tag, "_txdone"}, 32'(txd_cnt - d0), 32'd1);
  endtask

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    logic [7:0] a, b, op;
    int r0, low_seen, k;
    logic [5:0] ops [8];
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};

    repeat (3) @(negedge clk);
    chk("rst_rsTx", 32'(tx_line), 32'd1);
    chk("rst_tick_cnt", 32'(dut.brgen_cnt), 32'd0);
    chk("rst_a", 32'(dut.u_cap.a_q), 32'd0);
    chk("rst_b", 32'(dut.u_cap.b_q), 32'd0);
    chk("rst_op", 32'(dut.u_cap.op_q), 32'd0);
    chk("rst_state", 32'(dut.u_cap.st), 32'(CAP_WAIT_A));
    rst_n = 1'b1;
    repeat (BIT_CLK) @(negedge clk);

    run_txn("add_03_0c", 8'h03, 8'h0C, 8'h20);
    run_txn("sub_05_07", 8'h05, 8'h07, 8'h22);
    run_txn("sra_f0_02", 8'hF0, 8'h02, 8'h03);
    run_txn("srl_f0_02", 8'hF0, 8'h02, 8'h02);
    run_txn("undef_3f", 8'h5A, 8'hA5, 8'h3F);
    chk("undef_state", 32'(dut.u_cap.st), 32'(CAP_WAIT_A));

    // One-tick low glitch must not produce a byte.
    r0 = rx_cnt;
    rx_line = 1'b0;
    repeat (BD) @(negedge clk);
    rx_line = 1'b1;
    repeat (FRAME * BIT_CLK) @(negedge clk);
    chk("glitch_no_byte", 32'(rx_cnt - r0), 32'd0);
    chk("glitch_state", 32'(dut.u_cap.st), 32'(CAP_WAIT_A));
    run_txn("post_glitch", 8'h21, 8'h42, 8'hE4);

    // Reset after operand A aborts the sequence silently.
    send_byte(8'h55);
    chk("rstA_progress", 32'(dut.u_cap.st), 32'(CAP_WAIT_B));
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstA_clear_a", 32'(dut.u_cap.a_q), 32'd0);
    rst_n = 1'b1;
    low_seen = 0;
    for (int i = 0; i < int'(2 * FRAME * BIT_CLK); i++) begin
      @(negedge clk);
      if (tx_line !== 1'b1) low_seen++;
    end
    chk("rstA_rsTx_quiet", 32'(low_seen), 32'd0);
    run_txn("post_reset", 8'h01, 8'h01, 8'h20);

    // Randomised operands and opcodes, including undefined codes and op[7:6].
    for (int t = 0; t < 8; t++) begin
      k  = int'($urandom_range(0, 8));
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      op = 8'($urandom_range(0, 255));
      if (k < 8) op[5:0] = ops[k];
      if (k == 6 || k == 7) b = 8'($urandom_range(0, 9));
      run_txn($sformatf("rand%0d", t), a, b, op);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
